decimal_key_encoder: RTL

DECIMAL_KEY_ENCODER -- requirements
Module: decimal_key_encoder

---
 rtl/decimal_pkg.sv | 33 +++
 rtl/decimal_key_encoder_if.sv | 22 ++
 rtl/dec_sync.sv | 23 ++
 rtl/decimal_key_encoder.sv | 122 ++++++++++++
 4 files changed

// File: rtl/decimal_pkg.sv
// Shared types and constants for the decimal key encoder.
package decimal_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DEBOUNCE,
    HOLD,
    RELEASE
  } state_t;

  localparam int          DIGITS           = 10;
  localparam logic [3:0]  BCD_INVALID      = 4'b1111;
  localparam int unsigned DEBOUNCE_DEFAULT = 4;

  // Returns {err, code}; anything but one-hot is invalid.
  function automatic logic [4:0] encode(
    input logic [DIGITS-1:0] v
  );
    logic [3:0] n;
    logic [3:0] c;
    n = '0;
    c = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (v[i]) begin
        n = n + 4'd1;
        c = 4'(i);
      end
    end
    if (n == 4'd1) return {1'b0, c};
    return {1'b1, BCD_INVALID};
  endfunction

endpackage

// File: rtl/decimal_key_encoder_if.sv
// Encoded-key handshake bundle: producer drives code,
// consumer acknowledges with BCDReady.
interface decimal_key_encoder_if;
  logic [3:0] BCDOut;
  logic       BCDErr;
  logic       BCDValid;
  logic       BCDReady;

  modport master (
    output BCDOut,
    output BCDErr,
    output BCDValid,
    input  BCDReady
  );

  modport slave (
    input  BCDOut,
    input  BCDErr,
    input  BCDValid,
    output BCDReady
  );
endinterface

// File: rtl/dec_sync.sv
// Two-flop synchronizer for asynchronous key lines.
module dec_sync #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  logic [W-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/decimal_key_encoder.sv
// Debounced one-hot to BCD key encoder with valid/ready output.
// Define DECENC_DEBOUNCE_EN to enable the DEBOUNCE state.
module decimal_key_encoder
  import decimal_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DIGITS-1:0] DECIn,
  decimal_key_encoder_if.master bcd,
  output logic [7:0]        PressCount
);

  logic [DIGITS-1:0] s;
  state_t            state_q, state_d;
  logic [3:0]        out_q, out_d;
  logic              err_q, err_d;
  logic              vld_q, vld_d;
  logic [7:0]        cnt_q, cnt_d;

`ifdef DECENC_DEBOUNCE_EN
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);
  logic [DIGITS-1:0] pat_q, pat_d;
  logic [7:0]        dbc_q, dbc_d;
`else
  localparam bit DBC_OK =
    (DEBOUNCE_CYCLES >= 1) && (DEBOUNCE_CYCLES <= 255);
`endif

  dec_sync #(.W(DIGITS)) u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (DECIn),
    .q     (s)
  );

  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    err_d   = err_q;
    vld_d   = vld_q;
    cnt_d   = cnt_q;
`ifdef DECENC_DEBOUNCE_EN
    pat_d   = pat_q;
    dbc_d   = dbc_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef DECENC_DEBOUNCE_EN
        if (s != '0) begin
          pat_d   = s;
          dbc_d   = '0;
          state_d = DEBOUNCE;
        end
`else
        if (s != '0 && DBC_OK) begin
          {err_d, out_d} = encode(s);
          vld_d          = 1'b1;
          state_d        = HOLD;
        end
`endif
      end
      DEBOUNCE: begin
`ifdef DECENC_DEBOUNCE_EN
        if (s != pat_q) begin
          state_d = IDLE;
        end else if (dbc_q == LAST) begin
          {err_d, out_d} = encode(pat_q);
          vld_d          = 1'b1;
          state_d        = HOLD;
        end else begin
          dbc_d = dbc_q + 8'd1;
        end
`else
        state_d = IDLE;
`endif
      end
      HOLD: begin
        if (bcd.BCDReady) begin
          vld_d   = 1'b0;
          cnt_d   = cnt_q + 8'd1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (s == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      out_q   <= '0;
      err_q   <= 1'b0;
      vld_q   <= 1'b0;
      cnt_q   <= '0;
`ifdef DECENC_DEBOUNCE_EN
      pat_q   <= '0;
      dbc_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      err_q   <= err_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
`ifdef DECENC_DEBOUNCE_EN
      pat_q   <= pat_d;
      dbc_q   <= dbc_d;
`endif
    end
  end

  assign bcd.BCDOut   = out_q;
  assign bcd.BCDErr   = err_q;
  assign bcd.BCDValid = vld_q;
  assign PressCount   = cnt_q;

endmodule
